// File: rtl/mux4_vector_capture.sv
// Capture buffer for mux4 test vectors.
// Samples d0..d3, s and y of a live mux4 and packs each sample into a word
// {d0,d1,d2,d3,s,y}. The words are stored in a small on-chip memory and can
// then be streamed out, in write order, over a valid/ready port.
module mux4_vector_capture #(
   parameter int W = 4,
   parameter int SW = 2,
   parameter int DEPTH = 16,
   localparam int VW = 5*W + SW,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          cap_en,
   input  logic [W-1:0]  d0,
   input  logic [W-1:0]  d1,
   input  logic [W-1:0]  d2,
   input  logic [W-1:0]  d3,
   input  logic [SW-1:0] s,
   input  logic [W-1:0]  y,
   input  logic          dump,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [VW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          busy,
   output logic          full,
   output logic          overflow
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE,
      READ
   } state_t;

   localparam logic [AW:0]   CountZero  = '0;
   localparam logic [AW:0]   CountOne   = (AW+1)'(1);
   localparam logic [AW:0]   CountLast  = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0]   CountFull  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PtrZero    = '0;
   localparam logic [AW-1:0] PtrOne     = AW'(1);

   state_t          state_q, state_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   wrPtr_q, wrPtr_d;
   logic [AW-1:0]   rdPtr_q, rdPtr_d;
   logic            full_q, full_d;
   logic            overflow_q, overflow_d;
   logic            rdValid_q, rdValid_d;
   logic [VW-1:0]   rdData_q, rdData_d;

   logic [VW-1:0]   mem [DEPTH];
   logic            memWe;
   logic [VW-1:0]   memWrData;
   logic [AW-1:0]   rdPtrNext;

   assign memWrData = {d0, d1, d2, d3, s, y};
   assign rdPtrNext = rdPtr_q + PtrOne;

   // Next-state and datapath decisions; everything holds unless a state acts on it.
   // The read word is preloaded into rdData_d so rd_data is registered and only
   // changes on an accepted handshake, which keeps it stable while stalled.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      rdValid_d  = rdValid_q;
      rdData_d   = rdData_q;
      memWe      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CAPTURE;
               count_d    = CountZero;
               wrPtr_d    = PtrZero;
               overflow_d = 1'b0;
               full_d     = 1'b0;
            end else if (dump && (count_q != CountZero)) begin
               state_d   = READ;
               rdPtr_d   = PtrZero;
               rdValid_d = 1'b1;
               rdData_d  = mem[PtrZero];
            end
         end

         CAPTURE: begin
            if (start) begin
               count_d    = CountZero;
               wrPtr_d    = PtrZero;
               overflow_d = 1'b0;
               full_d     = 1'b0;
            end else begin
               if (cap_en && (count_q != CountFull)) begin
                  memWe   = 1'b1;
                  wrPtr_d = wrPtr_q + PtrOne;
                  count_d = count_q + CountOne;
                  if (count_q == CountLast) begin
                     state_d = DONE;
                     full_d  = 1'b1;
                  end
               end
               if (stop) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (start) begin
               state_d    = CAPTURE;
               count_d    = CountZero;
               wrPtr_d    = PtrZero;
               overflow_d = 1'b0;
               full_d     = 1'b0;
            end else begin
               if (cap_en && full_q) begin
                  overflow_d = 1'b1;
               end
               if (dump && (count_q != CountZero)) begin
                  state_d   = READ;
                  rdPtr_d   = PtrZero;
                  rdValid_d = 1'b1;
                  rdData_d  = mem[PtrZero];
               end
            end
         end

         READ: begin
            if (rdValid_q && rd_ready) begin
               if (({1'b0, rdPtr_q} + CountOne) == count_q) begin
                  state_d   = DONE;
                  rdValid_d = 1'b0;
               end else begin
                  rdPtr_d  = rdPtrNext;
                  rdData_d = mem[rdPtrNext];
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and control registers; reset aborts any capture or read at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= CountZero;
         wrPtr_q    <= PtrZero;
         rdPtr_q    <= PtrZero;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         rdValid_q  <= 1'b0;
         rdData_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         rdValid_q  <= rdValid_d;
         rdData_q   <= rdData_d;
      end
   end

   // Vector memory; contents are left undefined by reset since count guards reads.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[wrPtr_q] <= memWrData;
      end
   end

   assign rd_valid = rdValid_q;
   assign rd_data  = rdData_q;
   assign count    = count_q;
   assign full     = full_q;
   assign overflow = overflow_q;
   assign busy     = (state_q == CAPTURE) || (state_q == READ);

endmodule

// File: tb/tb_mux4_vector_capture.sv
// Testbench for mux4_vector_capture: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mux4_vector_capture;

   localparam int W     = 4;
   localparam int SW    = 2;
   localparam int DEPTH = 16;
   localparam int VW    = 5*W + SW;
   localparam int AW    = $clog2(DEPTH);

   localparam int MIdle = 0;
   localparam int MCap  = 1;
   localparam int MDone = 2;
   localparam int MRead = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          cap_en = 1'b0;
   logic          dump = 1'b0;
   logic          rd_ready = 1'b0;
   logic [W-1:0]  d0 = '0;
   logic [W-1:0]  d1 = '0;
   logic [W-1:0]  d2 = '0;
   logic [W-1:0]  d3 = '0;
   logic [SW-1:0] s = '0;
   logic [W-1:0]  y = '0;
   logic          rd_valid;
   logic [VW-1:0] rd_data;
   logic [AW:0]   count;
   logic          busy;
   logic          full;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   bit cmpEn = 1'b0;

   logic [VW-1:0] mWords[$];
   int            mMode = MIdle;
   int            mIdx = 0;
   bit            mOvf = 1'b0;

   logic [VW-1:0] gotWords[$];
   logic [VW-1:0] firstDump[$];
   logic [VW-1:0] firstWord;

   mux4_vector_capture #(.W(W), .SW(SW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .cap_en(cap_en),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .s(s), .y(y), .dump(dump),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .count(count), .busy(busy), .full(full), .overflow(overflow)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [W-1:0] muxOf(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] e,
                                          input logic [SW-1:0] sel);
      logic [W-1:0] arr [4];
      arr[0] = a; arr[1] = b; arr[2] = c; arr[3] = e;
      return arr[sel];
   endfunction

   // Word value by positional arithmetic: d0 is the most significant field.
   function automatic logic [VW-1:0] packWord(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic [W-1:0] e,
                                              input logic [SW-1:0] sel, input logic [W-1:0] yy);
      longint v;
      v = int'(a);
      v = v * (1 << W) + int'(b);
      v = v * (1 << W) + int'(c);
      v = v * (1 << W) + int'(e);
      v = v * (1 << SW) + int'(sel);
      v = v * (1 << W) + int'(yy);
      return VW'(v);
   endfunction

   // Reference model: the buffer is a queue, the read position an index.
   task automatic modelStep();
      case (mMode)
         MIdle: begin
            if (start) begin
               mWords.delete(); mOvf = 1'b0; mMode = MCap;
            end else if (dump && mWords.size() > 0) begin
               mMode = MRead; mIdx = 0;
            end
         end
         MCap: begin
            if (start) begin
               mWords.delete(); mOvf = 1'b0;
            end else begin
               if (cap_en && mWords.size() < DEPTH) mWords.push_back(packWord(d0, d1, d2, d3, s, y));
               if (mWords.size() == DEPTH || stop) mMode = MDone;
            end
         end
         MDone: begin
            if (start) begin
               mWords.delete(); mOvf = 1'b0; mMode = MCap;
            end else begin
               if (cap_en && mWords.size() == DEPTH) mOvf = 1'b1;
               if (dump && mWords.size() > 0) begin
                  mMode = MRead; mIdx = 0;
               end
            end
         end
         default: begin
            if (rd_ready) begin
               mIdx++;
               if (mIdx == mWords.size()) mMode = MDone;
            end
         end
      endcase
   endtask

   // Model advances on every active edge and clears on reset.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mWords.delete(); mMode = MIdle; mIdx = 0; mOvf = 1'b0;
         end else begin
            modelStep();
         end
      end
   end

   // Compare DUT against the model in the middle of every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (cmpEn && !reset) begin
            checkOutput("count", 32'(count), 32'(mWords.size()));
            checkOutput("full", 32'(full), 32'(mWords.size() == DEPTH));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
            checkOutput("busy", 32'(busy), 32'(mMode == MCap || mMode == MRead));
            checkOutput("rd_valid", 32'(rd_valid), 32'(mMode == MRead));
            if (mMode == MRead && mIdx < mWords.size())
               checkOutput("rd_data", 32'(rd_data), 32'(mWords[mIdx]));
         end
      end
   end

   task automatic setData(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] e, input logic [SW-1:0] sel);
      d0 = a; d1 = b; d2 = c; d3 = e; s = sel;
      y = muxOf(a, b, c, e, sel);
   endtask

   task automatic randomData();
      setData(W'($urandom), W'($urandom), W'($urandom), W'($urandom), SW'($urandom));
   endtask

   // Drive control inputs for exactly one active edge, returning at the next falling edge.
   task automatic applyStimulus(input bit st, input bit sp, input bit ce, input bit dm, input bit rr);
      start = st; stop = sp; cap_en = ce; dump = dm; rd_ready = rr;
      @(negedge clk);
   endtask

   // Consume the stream after a dump; readyMode 0=always, 1=toggle, 2=random.
   task automatic readOut(input int readyMode);
      bit rr;
      bit stalled;
      bit ended;
      logic [VW-1:0] held;
      gotWords.delete();
      stalled = 1'b0;
      ended = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (!rd_valid) begin
            ended = 1'b1;
            break;
         end
         if (readyMode == 0) rr = 1'b1;
         else if (readyMode == 1) rr = cyc[0];
         else rr = 1'($urandom);
         if (stalled) checkOutput("rd_data held while stalled", 32'(rd_data), 32'(held));
         if (rr) gotWords.push_back(rd_data);
         stalled = !rr;
         held = rd_data;
         applyStimulus(0, 0, 0, 0, rr);
      end
      if (!ended) checkOutput("read stream ended", 32'(0), 32'(1));
      rd_ready = 1'b0;
   endtask

   initial begin
      int nCap;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("reset count", 32'(count), 32'(0));
      checkOutput("reset rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("reset rd_data", 32'(rd_data), 32'(0));
      checkOutput("reset busy", 32'(busy), 32'(0));
      checkOutput("reset full", 32'(full), 32'(0));
      checkOutput("reset overflow", 32'(overflow), 32'(0));
      reset = 1'b0;
      cmpEn = 1'b1;
      @(negedge clk);

      // Four captures of a known mux4, then a full-speed dump.
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         setData(4'd1, 4'd2, 4'd3, 4'd4, SW'(i));
         applyStimulus(0, 0, 1, 0, 0);
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("t1 count", 32'(count), 32'(4));
      checkOutput("pack model pin", 32'(packWord(4'd1, 4'd2, 4'd3, 4'd4, 2'd2, 4'd3)), 32'h48D23);
      applyStimulus(0, 0, 0, 1, 1);
      readOut(0);
      checkOutput("t1 words", 32'(gotWords.size()), 32'(4));
      if (gotWords.size() == 4) begin
         checkOutput("t1 word0", 32'(gotWords[0]), 32'h48D01);
         checkOutput("t1 word1", 32'(gotWords[1]), 32'h48D12);
         checkOutput("t1 word2", 32'(gotWords[2]), 32'h48D23);
         checkOutput("t1 word3", 32'(gotWords[3]), 32'h48D34);
      end
      checkOutput("t1 rd_valid after", 32'(rd_valid), 32'(0));

      // Fill the buffer, then overflow it.
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         randomData();
         if (i == 0) firstWord = {d0, d1, d2, d3, s, y};
         applyStimulus(0, 0, 1, 0, 0);
      end
      checkOutput("t2 full", 32'(full), 32'(1));
      checkOutput("t2 count", 32'(count), 32'(16));
      checkOutput("t2 busy", 32'(busy), 32'(0));
      randomData();
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t2 overflow", 32'(overflow), 32'(1));
      checkOutput("t2 count kept", 32'(count), 32'(16));
      applyStimulus(0, 0, 0, 1, 1);
      readOut(0);
      checkOutput("t2 words", 32'(gotWords.size()), 32'(16));
      if (gotWords.size() > 0) checkOutput("t2 first word", 32'(gotWords[0]), 32'(firstWord));
      firstDump = gotWords;

      // Replay with a stalling consumer; sequence must be identical.
      applyStimulus(0, 0, 0, 1, 0);
      readOut(1);
      checkOutput("t3 words", 32'(gotWords.size()), 32'(16));
      if (gotWords.size() == firstDump.size())
         for (int i = 0; i < gotWords.size(); i++)
            checkOutput("t3 replay word", 32'(gotWords[i]), 32'(firstDump[i]));

      // Restart from DONE, restart inside CAPTURE, then stop together with a sample.
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t4 restart count", 32'(count), 32'(0));
      checkOutput("t4 overflow cleared", 32'(overflow), 32'(0));
      checkOutput("t4 busy", 32'(busy), 32'(1));
      randomData();
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("t4 start ignores cap_en", 32'(count), 32'(0));
      for (int i = 0; i < 3; i++) begin
         randomData();
         applyStimulus(0, (i == 2), 1, 0, 0);
      end
      checkOutput("t4 stop count", 32'(count), 32'(3));
      checkOutput("t4 stop busy", 32'(busy), 32'(0));

      // Asynchronous reset in the middle of a stalled read.
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t5 reading", 32'(rd_valid), 32'(1));
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("t5 rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("t5 count", 32'(count), 32'(0));
      checkOutput("t5 busy", 32'(busy), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Dump with nothing captured is ignored.
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("t6 idle dump rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("t6 idle dump busy", 32'(busy), 32'(0));

      // Random captures; every dumped word must describe a consistent mux4.
      for (int round = 0; round < 4; round++) begin
         nCap = 0;
         applyStimulus(1, 0, 0, 0, 0);
         for (int i = 0; i < 20; i++) begin
            bit ce;
            ce = ($urandom_range(0, 3) != 0);
            randomData();
            if (ce) nCap++;
            applyStimulus(0, 0, ce, 0, 0);
         end
         if (nCap > DEPTH) nCap = DEPTH;
         applyStimulus(0, 1, 0, 0, 0);
         if (nCap == 0) continue;
         applyStimulus(0, 0, 0, 1, 0);
         readOut(2);
         checkOutput("t6 words", 32'(gotWords.size()), 32'(nCap));
         foreach (gotWords[i]) begin
            logic [VW-1:0] w;
            w = gotWords[i];
            checkOutput("t6 y==d[s]", 32'(w[W-1:0]),
                        32'(muxOf(w[5*W+SW-1 -: W], w[4*W+SW-1 -: W], w[3*W+SW-1 -: W],
                                  w[2*W+SW-1 -: W], w[W+SW-1 -: SW])));
         end
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
